// File: rtl/uart_sha_pkg.sv
// Shared constants and types for the UART SHA-256 job host: protocol characters,
// frame layout, FSM state and error encodings.
package uart_sha_pkg;

    localparam logic [7:0] CH_HELLO  = 8'h48; // 'H'
    localparam logic [7:0] CH_ABORT  = 8'h52; // 'R'
    localparam logic [7:0] CH_READY  = 8'h31; // '1'
    localparam logic [7:0] CH_OK     = 8'h4F; // 'O'
    localparam logic [7:0] CH_START  = 8'h53; // 'S'
    localparam logic [7:0] CH_FOUND  = 8'h59; // 'Y'
    localparam logic [7:0] CH_ERR    = 8'h45; // 'E'
    localparam logic [7:0] CH_ERR_LC = 8'h65; // 'e'

    localparam int         FRAME_LEN  = 136;
    localparam logic [7:0] OFF_DATA   = 8'd0;
    localparam logic [7:0] OFF_STATE  = 8'd12;
    localparam logic [7:0] OFF_TARGET = 8'd44;
    localparam logic [7:0] OFF_NONCE  = 8'd76;
    localparam logic [7:0] OFF_POS    = 8'd80;
    localparam logic [7:0] OFF_PAD    = 8'd84;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HELLO   = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_WAIT_S  = 3'd3,
        ST_WAIT_Y  = 3'd4,
        ST_NONCE   = 3'd5,
        ST_ABORT   = 3'd6
    } host_state_t;

    typedef enum logic [2:0] {
        ERR_NONE       = 3'd0,
        ERR_TIMEOUT    = 3'd1,
        ERR_REJECT     = 3'd2,
        ERR_UNEXPECTED = 3'd3,
        ERR_ABORTED    = 3'd4
    } host_err_t;

    typedef struct packed {
        logic [11:0][7:0] data;
        logic [255:0]     state;
        logic [31:0][7:0] target;
        logic [31:0]      nonce_base;
        logic [31:0]      position;
    } job_t;

    // Classifies a byte that the current state did not expect.
    function automatic host_err_t rx_fault(input logic [7:0] b);
        return (b == CH_ERR || b == CH_ERR_LC) ? ERR_REJECT : ERR_UNEXPECTED;
    endfunction

endpackage

// File: rtl/uart_sha_host_if.sv
// Byte-stream link between the job host and its uart_tx/uart_rx pair.
interface uart_sha_host_if;
    logic [7:0] out_tx_data;
    logic       out_tx_valid;
    logic       in_tx_ready;
    logic [7:0] in_rx_data;
    logic       in_rx_valid;
    logic       out_rx_ready;

    modport master (
        output out_tx_data, out_tx_valid, out_rx_ready,
        input  in_tx_ready, in_rx_data, in_rx_valid
    );

    modport slave (
        input  out_tx_data, out_tx_valid, out_rx_ready,
        output in_tx_ready, in_rx_data, in_rx_valid
    );
endinterface

// File: rtl/uart_sha_frame_mux.sv
// Selects job frame byte idx from the latched job; bytes past the position word are zero.
module uart_sha_frame_mux
    import uart_sha_pkg::*;
(
    input  job_t       job,
    input  logic [7:0] idx,
    output logic [7:0] frame_byte
);

    logic [4:0] off;

    always_comb begin
        frame_byte = 8'h00;
        off        = 5'd0;
        if (idx < OFF_STATE) begin
            frame_byte = job.data[idx[3:0]];
        end else if (idx < OFF_TARGET) begin
            off        = 5'(idx - OFF_STATE);
            frame_byte = job.state[{off, 3'b000} +: 8];
        end else if (idx < OFF_NONCE) begin
            off        = 5'(idx - OFF_TARGET);
            frame_byte = job.target[off];
        end else if (idx < OFF_POS) begin
            off        = 5'(idx - OFF_NONCE);
            frame_byte = job.nonce_base[{off[1:0], 3'b000} +: 8];
        end else if (idx < OFF_PAD) begin
            off        = 5'(idx - OFF_POS);
            frame_byte = job.position[{off[1:0], 3'b000} +: 8];
        end
    end

endmodule

// File: rtl/uart_sha_host.sv
// Host-side initiator for the UART SHA-256 job protocol: hello, 136-byte frame,
// 'S'/'Y' acknowledgements and a 4-byte little-endian nonce, with timeout and abort.
module uart_sha_host
    import uart_sha_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES      = 100_000_000,
    parameter int unsigned HASH_TIMEOUT_CYCLES = 0
) (
    input  logic             clk,
    input  logic             in_rst,
    input  logic             in_start,
    input  logic             in_abort,
    input  logic [11:0][7:0] in_job_data,
    input  logic [255:0]     in_job_state,
    input  logic [31:0][7:0] in_job_target,
    input  logic [31:0]      in_job_nonce_base,
    input  logic [31:0]      in_job_position,
    uart_sha_host_if.master  bus,
    output logic             out_busy,
    output logic             out_done,
    output logic             out_error,
    output logic [2:0]       out_err_code,
    output logic [31:0]      out_nonce
);

    localparam logic [2:0] S_IDLE    = ST_IDLE;
    localparam logic [2:0] S_HELLO   = ST_HELLO;
    localparam logic [2:0] S_PAYLOAD = ST_PAYLOAD;
    localparam logic [2:0] S_WAIT_S  = ST_WAIT_S;
    localparam logic [2:0] S_WAIT_Y  = ST_WAIT_Y;
    localparam logic [2:0] S_NONCE   = ST_NONCE;
    localparam logic [2:0] S_ABORT   = ST_ABORT;

    localparam logic [31:0] TO_LIM   = 32'(TIMEOUT_CYCLES);
    localparam logic [31:0] HASH_LIM = 32'(HASH_TIMEOUT_CYCLES);
    localparam logic [7:0]  LAST_IDX = 8'(FRAME_LEN - 1);

    logic [2:0]  state;
    job_t        job;
    logic [7:0]  idx;
    logic [7:0]  frame_byte;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        rx_ready;
    logic        abort_r;
    logic [31:0] cnt;
    logic [1:0]  nbytes;
    logic [23:0] nonce_sh;
    logic        tx_fire;
    logic        rx_hit;
    logic        wait_to;
    logic        hash_to;
    logic        abort_take;
    logic        err_fire;
    host_err_t   err_val;

    uart_sha_frame_mux u_mux (
        .job        (job),
        .idx        (idx),
        .frame_byte (frame_byte)
    );

    assign tx_fire    = tx_valid & bus.in_tx_ready;
    assign rx_hit     = bus.in_rx_valid;
    assign wait_to    = (cnt == TO_LIM - 32'd1);
    assign hash_to    = (HASH_LIM != 32'd0) && (cnt == HASH_LIM - 32'd1);
    assign abort_take = in_abort && (state != S_IDLE) && (state != S_ABORT);

    // During PAYLOAD the byte comes straight from the frame mux so the stream has no gaps.
    assign bus.out_tx_data  = (state == S_PAYLOAD) ? frame_byte : tx_byte;
    assign bus.out_tx_valid = tx_valid;
    assign bus.out_rx_ready = rx_ready;
    assign out_busy         = (state != S_IDLE);

    always_comb begin
        err_fire = 1'b0;
        err_val  = ERR_NONE;
        if (state == S_ABORT) begin
            if (abort_r && !tx_valid &&
                ((rx_hit && bus.in_rx_data == CH_OK) || wait_to)) begin
                err_fire = 1'b1;
                err_val  = ERR_ABORTED;
            end
        end else if (state != S_IDLE && !in_abort) begin
            case (state)
                S_HELLO: begin
                    if (rx_hit) begin
                        if (tx_valid || bus.in_rx_data != CH_READY) begin
                            err_fire = 1'b1;
                            err_val  = rx_fault(bus.in_rx_data);
                        end
                    end else if (!tx_valid && wait_to) begin
                        err_fire = 1'b1;
                        err_val  = ERR_TIMEOUT;
                    end
                end
                S_PAYLOAD: begin
                    if (rx_hit) begin
                        err_fire = 1'b1;
                        err_val  = rx_fault(bus.in_rx_data);
                    end
                end
                S_WAIT_S: begin
                    if (rx_hit) begin
                        if (bus.in_rx_data != CH_START) begin
                            err_fire = 1'b1;
                            err_val  = rx_fault(bus.in_rx_data);
                        end
                    end else if (wait_to) begin
                        err_fire = 1'b1;
                        err_val  = ERR_TIMEOUT;
                    end
                end
                S_WAIT_Y: begin
                    if (rx_hit) begin
                        if (bus.in_rx_data != CH_FOUND) begin
                            err_fire = 1'b1;
                            err_val  = rx_fault(bus.in_rx_data);
                        end
                    end else if (hash_to) begin
                        err_fire = 1'b1;
                        err_val  = ERR_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (in_rst) begin
            state        <= S_IDLE;
            tx_valid     <= 1'b0;
            tx_byte      <= 8'h00;
            idx          <= 8'd0;
            abort_r      <= 1'b0;
            cnt          <= 32'd0;
            nbytes       <= 2'd0;
            rx_ready     <= 1'b0;
            out_done     <= 1'b0;
            out_error    <= 1'b0;
            out_err_code <= 3'd0;
            out_nonce    <= 32'd0;
        end else begin
            out_done  <= 1'b0;
            out_error <= 1'b0;
            rx_ready  <= 1'b1;
            cnt       <= rx_hit ? 32'd0 : cnt + 32'd1;
            if (err_fire) begin
                state        <= S_IDLE;
                tx_valid     <= 1'b0;
                out_error    <= 1'b1;
                out_err_code <= err_val;
            end else if (abort_take) begin
                // Freeze the in-flight byte so it still completes after leaving PAYLOAD.
                state   <= S_ABORT;
                abort_r <= 1'b0;
                tx_byte <= bus.out_tx_data;
                if (tx_fire) tx_valid <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (in_start) begin
                            state        <= S_HELLO;
                            tx_valid     <= 1'b1;
                            tx_byte      <= CH_HELLO;
                            out_err_code <= 3'd0;
                            out_nonce    <= 32'd0;
                        end
                    end
                    S_HELLO: begin
                        if (tx_fire) begin
                            tx_valid <= 1'b0;
                            cnt      <= 32'd0;
                        end else if (rx_hit) begin
                            state    <= S_PAYLOAD;
                            idx      <= 8'd0;
                            tx_valid <= 1'b1;
                        end
                    end
                    S_PAYLOAD: begin
                        if (tx_fire) begin
                            if (idx == LAST_IDX) begin
                                state    <= S_WAIT_S;
                                tx_valid <= 1'b0;
                                cnt      <= 32'd0;
                            end else begin
                                idx <= idx + 8'd1;
                            end
                        end
                    end
                    S_WAIT_S: if (rx_hit) state <= S_WAIT_Y;
                    S_WAIT_Y: begin
                        if (rx_hit) begin
                            state  <= S_NONCE;
                            nbytes <= 2'd0;
                        end
                    end
                    S_NONCE: begin
                        if (rx_hit) begin
                            nbytes <= nbytes + 2'd1;
                            if (nbytes == 2'd3) begin
                                out_nonce <= {bus.in_rx_data, nonce_sh};
                                out_done  <= 1'b1;
                                state     <= S_IDLE;
                            end
                        end
                    end
                    S_ABORT: begin
                        if (!abort_r) begin
                            if (!tx_valid || tx_fire) begin
                                tx_valid <= 1'b1;
                                tx_byte  <= CH_ABORT;
                                abort_r  <= 1'b1;
                            end
                        end else if (tx_fire) begin
                            tx_valid <= 1'b0;
                            cnt      <= 32'd0;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && in_start) begin
            job <= {in_job_data, in_job_state, in_job_target, in_job_nonce_base, in_job_position};
        end
        if (state == S_NONCE && rx_hit && !in_abort && nbytes != 2'd3) begin
            nonce_sh[{nbytes, 3'b000} +: 8] <= bus.in_rx_data;
        end
    end

endmodule
